// File: rtl/tru_noi_tiep_pkg.sv
// rtl/tru_noi_tiep_pkg.sv - shared FSM encoding and default width for the bit-serial subtractor
package tru_noi_tiep_pkg;

   localparam int TRU_N = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tru_1bit.sv
// rtl/tru_1bit.sv - 1-bit full-subtractor cell
module tru_1bit (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = a_i ^ b_i ^ bin_i;
   assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/tru_noi_tiep.sv
// rtl/tru_noi_tiep.sv - bit-serial N-bit subtractor, LSB first, start/done handshake
module tru_noi_tiep
   import tru_noi_tiep_pkg::*;
#(
   parameter int N = TRU_N
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] d_o,
   output logic         bout_o,
   output logic         ovf_o
);

   localparam int CW = $clog2(N);

   state_t         state_q, state_d;
   logic [N-1:0]   sa_q, sa_d, sb_q, sb_d, res_q, res_d, d_q, d_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
   logic           diff, br_next, accept;

   tru_1bit u_cell (
      .a_i    (sa_q[0]),
      .b_i    (sb_q[0]),
      .bin_i  (br_q),
      .d_o    (diff),
      .bout_o (br_next)
   );

   assign accept = start_i && (state_q != ST_RUN);

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      res_d   = res_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      if (accept) begin
         state_d = ST_RUN;
         sa_d    = a_i;
         sb_d    = b_i;
         br_d    = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               sa_d  = sa_q >> 1;
               sb_d  = sb_q >> 1;
               res_d = {diff, res_q[N-1:1]};
               br_d  = br_next;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) begin
                  state_d = ST_DONE;
                  d_d     = {diff, res_q[N-1:1]};
                  bout_d  = br_next;
                  // on the last step sa_q[0]/sb_q[0] are the operand sign bits
                  ovf_d   = (sa_q[0] ^ sb_q[0]) & (diff ^ sa_q[0]);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy_o = (state_q == ST_RUN);
   assign done_o = (state_q == ST_DONE);
   assign d_o    = d_q;
   assign bout_o = bout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_tru_noi_tiep.sv
// tb/tb_tru_noi_tiep.sv - directed and random self-checking bench for tru_noi_tiep
module tb_tru_noi_tiep;

   logic       clk = 1'b0;
   logic       rst, start, busy, done, bout, ovf;
   logic [7:0] a, b, d;
   int         compared = 0;
   int         mismatched = 0;

   always #5 clk = ~clk;

   tru_noi_tiep #(.N(8)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .a_i     (a),
      .b_i     (b),
      .busy_o  (busy),
      .done_o  (done),
      .d_o     (d),
      .bout_o  (bout),
      .ovf_o   (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!done && n < 30);
   endtask

   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo);
      int n;
      a = av;
      b = bv;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(n);
      chk({tag, "_lat"}, 32'(n), 32'd8);
      chk({tag, "_d"}, 32'(d), 32'(ed));
      chk({tag, "_bout"}, 32'(bout), 32'(eb));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int n;
      int pulses;
      logic [7:0] ra, rb, rd;
      logic [8:0] full;

      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_d", 32'(d), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      step();

      run_op("t09m05", 8'h09, 8'h05, 8'h04, 1'b0, 1'b0);
      step();
      chk("done_drops", 32'(done), 32'd0);
      chk("d_held", 32'(d), 32'h04);
      run_op("t05m09", 8'h05, 8'h09, 8'hFC, 1'b1, 1'b0);
      run_op("t80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      run_op("t00m00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      run_op("t7Fm_FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
      step();

      // start re-pulsed mid-run must be ignored
      a = 8'h09;
      b = 8'h05;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      a = 8'hFF;
      b = 8'h00;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ign_busy", 32'(busy), 32'd1);
      wait_done(n);
      chk("ign_lat", 32'(n + 3), 32'd8);
      chk("ign_d", 32'(d), 32'h04);
      chk("ign_bout", 32'(bout), 32'd0);
      step();

      // start held through DONE: back-to-back every 9 cycles
      a = 8'h10;
      b = 8'h01;
      start = 1'b1;
      step();
      wait_done(n);
      chk("b2b_lat0", 32'(n), 32'd8);
      chk("b2b_d0", 32'(d), 32'h0F);
      a = 8'h01;
      b = 8'h02;
      wait_done(n);
      chk("b2b_per1", 32'(n), 32'd9);
      chk("b2b_d1", 32'(d), 32'hFF);
      chk("b2b_bout1", 32'(bout), 32'd1);
      chk("b2b_busy1", 32'(busy), 32'd0);
      wait_done(n);
      chk("b2b_per2", 32'(n), 32'd9);
      start = 1'b0;
      step();
      chk("b2b_idle_done", 32'(done), 32'd0);
      chk("b2b_idle_busy", 32'(busy), 32'd0);

      // reset 3 cycles into RUN aborts with no done pulse
      a = 8'h33;
      b = 8'h11;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_d", 32'(d), 32'd0);
      chk("abort_bout", 32'(bout), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);
      run_op("post_abort", 8'h20, 8'h30, 8'hF0, 1'b1, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         full = {1'b0, ra} - {1'b0, rb};
         rd = full[7:0];
         run_op("rnd", ra, rb, rd, ra < rb, (ra[7] != rb[7]) && (rd[7] != ra[7]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
